fifo_sync_prog: RTL and testbench
=================================

Name: fifo_sync_prog

Overview:
Single-clock parametrised FIFO, the successor to the team's dual-clock FIFO, for blocks that share one clock domain.
- Supports arbitrary (non-power-of-2) depth.
- Adds programmable almost-full/almost-empty thresholds, an occupancy count, a high-water mark, a synchronous flush, and one-cycle overflow/underflow error pulses.
- Sits between producer and consumer logic inside one clock domain.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 16, number of entries (>=2, need not be a power of 2)
AF_LEVEL, 14, almost_full_o asserts when count >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 2, almost_empty_o asserts when count <= AE_LEVEL (0..DEPTH-1)
PTR_WIDTH, clog2(DEPTH), pointer width (derived; not overridden)
CNT_WIDTH, clog2(DEPTH+1), count width (derived; not overridden)

Ports:
clk_i  in  1  single clock, all logic on rising edge
rst_i  in  1  reset, synchronous, active-high
flush_i  in  1  synchronous flush: empties the FIFO, clears the high-water mark
wr_en_i  in  1  write request
wdata_i  in  WIDTH  write data
rd_en_i  in  1  read request
rdata_o  out  WIDTH  read data, registered
full_o  out  1  count == DEPTH
empty_o  out  1  count == 0
almost_full_o  out  1  count >= AF_LEVEL
almost_empty_o  out  1  count <= AE_LEVEL
count_o  out  CNT_WIDTH  current occupancy
max_count_o  out  CNT_WIDTH  peak occupancy since reset/flush
wr_error_o  out  1  one-cycle pulse: write requested while full
rd_error_o  out  1  one-cycle pulse: read requested while empty

Behaviour:
- Reset (rst_i=1 at an edge) values:
  - wr_ptr=rd_ptr=0, count_o=0, max_count_o=0, rdata_o=0.
  - full_o=0, empty_o=1, almost_full_o=0, almost_empty_o=1, wr_error_o=rd_error_o=0.
  - Storage array is not reset.
- Reset mid-operation discards all contents; wr_en_i/rd_en_i in that cycle are ignored.
- Priority: rst_i > flush_i > rd/wr.
- Flush cycle:
  - Pointers and count go to 0; max_count_o goes to 0.
  - rdata_o holds its value; error pulses are 0.
  - wr_en_i/rd_en_i in the same cycle are ignored.
- Accept rules use the registered flags of the current cycle:
  - wr_acc = wr_en_i & ~full_o
  - rd_acc = rd_en_i & ~empty_o
- Full and write+read together: read accepted, write rejected, wr_error_o pulses, count becomes DEPTH-1.
- Empty and write+read together: write accepted, read rejected, rd_error_o pulses, count becomes 1.
- Both accepted (0<count<DEPTH): count unchanged, both pointers advance.
- Error timing: wr_error_o=1 in the cycle after wr_en_i & full_o; rd_error_o likewise for rd_en_i & empty_o. Otherwise 0. Neither pointers nor count change on a rejected request.
- Read latency: on rd_acc, rdata_o <= mem[rd_ptr], valid the next cycle. rdata_o holds when there is no accepted read.
- Write: on wr_acc, mem[wr_ptr] <= wdata_i.
- Pointer wrap: ptr == DEPTH-1 -> next 0, otherwise ptr+1. Explicit compare; no modulo-2^n reliance.
- count_next = count + wr_acc - rd_acc, computed in CNT_WIDTH with no overflow possible.
- Flags and max_count_o are registered from count_next, so they are consistent with count_o in the same cycle.
- High-water mark: max_count_o <= max(max_count_o, count_next).
- Only data written and accepted is read out, in FIFO order.

Decomposition:
- Shared package fifo_pkg:
  - clog2 function;
  - default WIDTH/DEPTH constants;
  - ptr_inc(ptr, DEPTH) wrap function, also reused by future FIFO variants.
- Sub-module fifo_mem_1r1w (WIDTH, DEPTH):
  - synchronous write port;
  - registered read port with read enable;
  - no reset.
- Control, count, flags and errors stay in fifo_sync_prog.

Test Plan:
1. Reset, then 16 writes of 0x01..0x10 -> after 16th accepted write: count_o=16, full_o=1, almost_full_o=1 from count 14; max_count_o=16.
2. After test 1, 16 reads -> rdata_o = 0x01..0x10 in order, each one cycle after its read; final empty_o=1, almost_empty_o=1 at count<=2, max_count_o stays 16.
3. Full, then a 17th write -> wr_error_o=1 for exactly one cycle, count_o stays 16, contents intact. Empty, then a read -> rd_error_o pulse, rdata_o unchanged.
4. Full plus simultaneous wr/rd -> read returns oldest word, wr_error_o=1, count_o=15. Empty plus simultaneous wr/rd -> rd_error_o=1, count_o=1, the written word is readable next.
5. DEPTH=10: 300 random-interleaved wr/rd cycles against a scoreboard -> data order exact, pointers wrap 9->0, count_o always 0..10, flags always consistent with count_o.
6. 8 writes, then flush_i with wr_en_i=1 -> next cycle count_o=0, empty_o=1, max_count_o=0, no errors. rst_i asserted mid-stream -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: sizing, pointer wrap and occupancy-derived status flags.
// Reused by every FIFO flavour so that flag semantics stay identical across variants.
package fifo_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 16;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_flags_t;

    // Smallest r such that 2**r >= n.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 32'sd0;
        v = 32'sd1;
        while (v < n) begin
            v = v * 32'sd2;
            r = r + 32'sd1;
        end
        return r;
    endfunction

    // Explicit wrap so non-power-of-two depths never rely on natural overflow.
    function automatic int ptr_inc(input int ptr, input int depth);
        if (ptr == depth - 32'sd1) begin
            return 32'sd0;
        end else begin
            return ptr + 32'sd1;
        end
    endfunction

    function automatic fifo_flags_t flags_of(input int cnt, input int depth,
                                             input int af, input int ae);
        fifo_flags_t f;
        f.full         = (cnt == depth);
        f.empty        = (cnt == 32'sd0);
        f.almost_full  = (cnt >= af);
        f.almost_empty = (cnt <= ae);
        return f;
    endfunction

endpackage

// File: rtl/fifo_mem_1r1w.sv
// Simple dual-port storage: synchronous write, registered read with enable.
// Deliberately unreset so it maps onto plain RAM; the owner masks stale read data.
module fifo_mem_1r1w
    import fifo_pkg::*;
#(
    parameter int  WIDTH = DEFAULT_WIDTH,
    parameter int  DEPTH = DEFAULT_DEPTH,
    localparam int AW    = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [WIDTH-1:0] rdata_r;

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered read port; holds its word while re is low.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata_r <= mem_r[raddr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/fifo_sync_prog.sv
// Single-clock FIFO with arbitrary depth, programmable almost flags, occupancy,
// high-water mark, synchronous flush and one-cycle overflow/underflow pulses.
module fifo_sync_prog
    import fifo_pkg::*;
#(
    parameter int  WIDTH     = DEFAULT_WIDTH,
    parameter int  DEPTH     = DEFAULT_DEPTH,
    parameter int  AF_LEVEL  = 14,
    parameter int  AE_LEVEL  = 2,
    localparam int PTR_WIDTH = clog2(DEPTH),
    localparam int CNT_WIDTH = clog2(DEPTH + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 wr_en_i,
    input  logic [WIDTH-1:0]     wdata_i,
    input  logic                 rd_en_i,
    output logic [WIDTH-1:0]     rdata_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic                 almost_full_o,
    output logic                 almost_empty_o,
    output logic [CNT_WIDTH-1:0] count_o,
    output logic [CNT_WIDTH-1:0] max_count_o,
    output logic                 wr_error_o,
    output logic                 rd_error_o
);

    localparam fifo_flags_t FLAGS_EMPTY = flags_of(32'sd0, DEPTH, AF_LEVEL, AE_LEVEL);

    logic [PTR_WIDTH-1:0] wr_ptr_r;
    logic [PTR_WIDTH-1:0] rd_ptr_r;
    logic [PTR_WIDTH-1:0] wr_ptr_next_s;
    logic [PTR_WIDTH-1:0] rd_ptr_next_s;
    logic [CNT_WIDTH-1:0] count_r;
    logic [CNT_WIDTH-1:0] count_next_s;
    logic [CNT_WIDTH-1:0] max_count_r;
    logic [CNT_WIDTH-1:0] max_next_s;
    fifo_flags_t          flags_r;
    fifo_flags_t          flags_next_s;
    logic                 wr_acc_s;
    logic                 rd_acc_s;
    logic                 wr_error_r;
    logic                 rd_error_r;
    logic                 rdata_valid_r;
    logic [WIDTH-1:0]     mem_rdata_s;

    // Accept decisions use this cycle's registered flags; reset and flush suppress both.
    always_comb begin
        wr_acc_s = 1'b0;
        rd_acc_s = 1'b0;
        if (!rst_i && !flush_i) begin
            wr_acc_s = wr_en_i & ~flags_r.full;
            rd_acc_s = rd_en_i & ~flags_r.empty;
        end else begin
            wr_acc_s = 1'b0;
            rd_acc_s = 1'b0;
        end
    end

    // Next-state occupancy, pointers, flags and high-water mark.
    always_comb begin
        count_next_s  = count_r + CNT_WIDTH'(wr_acc_s) - CNT_WIDTH'(rd_acc_s);
        wr_ptr_next_s = wr_acc_s ? PTR_WIDTH'(ptr_inc(int'(wr_ptr_r), DEPTH)) : wr_ptr_r;
        rd_ptr_next_s = rd_acc_s ? PTR_WIDTH'(ptr_inc(int'(rd_ptr_r), DEPTH)) : rd_ptr_r;
        max_next_s    = (count_next_s > max_count_r) ? count_next_s : max_count_r;
        flags_next_s  = flags_of(int'(count_next_s), DEPTH, AF_LEVEL, AE_LEVEL);
    end

    // Control state: reset beats flush, flush beats normal traffic.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_r      <= {PTR_WIDTH{1'b0}};
            rd_ptr_r      <= {PTR_WIDTH{1'b0}};
            count_r       <= {CNT_WIDTH{1'b0}};
            max_count_r   <= {CNT_WIDTH{1'b0}};
            flags_r       <= FLAGS_EMPTY;
            wr_error_r    <= 1'b0;
            rd_error_r    <= 1'b0;
            rdata_valid_r <= 1'b0;
        end else if (flush_i) begin
            wr_ptr_r      <= {PTR_WIDTH{1'b0}};
            rd_ptr_r      <= {PTR_WIDTH{1'b0}};
            count_r       <= {CNT_WIDTH{1'b0}};
            max_count_r   <= {CNT_WIDTH{1'b0}};
            flags_r       <= FLAGS_EMPTY;
            wr_error_r    <= 1'b0;
            rd_error_r    <= 1'b0;
        end else begin
            wr_ptr_r      <= wr_ptr_next_s;
            rd_ptr_r      <= rd_ptr_next_s;
            count_r       <= count_next_s;
            max_count_r   <= max_next_s;
            flags_r       <= flags_next_s;
            wr_error_r    <= wr_en_i & flags_r.full;
            rd_error_r    <= rd_en_i & flags_r.empty;
            rdata_valid_r <= rdata_valid_r | rd_acc_s;
        end
    end

    fifo_mem_1r1w #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk_i),
        .we    (wr_acc_s),
        .waddr (wr_ptr_r),
        .wdata (wdata_i),
        .re    (rd_acc_s),
        .raddr (rd_ptr_r),
        .rdata (mem_rdata_s)
    );

    // The RAM read register has no reset, so it reads as zero until the first accepted read.
    assign rdata_o        = rdata_valid_r ? mem_rdata_s : {WIDTH{1'b0}};
    assign full_o         = flags_r.full;
    assign empty_o        = flags_r.empty;
    assign almost_full_o  = flags_r.almost_full;
    assign almost_empty_o = flags_r.almost_empty;
    assign count_o        = count_r;
    assign max_count_o    = max_count_r;
    assign wr_error_o     = wr_error_r;
    assign rd_error_o     = rd_error_r;

endmodule

// File: tb/tb_fifo_sync_prog.sv
// Self-checking bench for fifo_sync_prog: directed scenarios on a depth-16 instance
// and a randomized run on a depth-10 instance, both against a queue-based model.
module tb_fifo_sync_prog;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       flush = 1'b0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic [7:0] wdata = 8'h00;

    logic [7:0] a_rdata, b_rdata;
    logic       a_full, a_empty, a_af, a_ae, a_werr, a_rerr;
    logic       b_full, b_empty, b_af, b_ae, b_werr, b_rerr;
    logic [4:0] a_count, a_max;
    logic [3:0] b_count, b_max;

    fifo_sync_prog #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2)) dut_a (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .wr_en_i(wr_en), .wdata_i(wdata),
        .rd_en_i(rd_en), .rdata_o(a_rdata), .full_o(a_full), .empty_o(a_empty),
        .almost_full_o(a_af), .almost_empty_o(a_ae), .count_o(a_count),
        .max_count_o(a_max), .wr_error_o(a_werr), .rd_error_o(a_rerr)
    );

    fifo_sync_prog #(.WIDTH(8), .DEPTH(10), .AF_LEVEL(8), .AE_LEVEL(3)) dut_b (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .wr_en_i(wr_en), .wdata_i(wdata),
        .rd_en_i(rd_en), .rdata_o(b_rdata), .full_o(b_full), .empty_o(b_empty),
        .almost_full_o(b_af), .almost_empty_o(b_ae), .count_o(b_count),
        .max_count_o(b_max), .wr_error_o(b_werr), .rd_error_o(b_rerr)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model of the instance under test.
    logic [7:0] mq[$];
    int         mdepth = 16;
    int         maf = 14;
    int         mae = 2;
    int         mmax = 0;
    logic [7:0] m_rdata = 8'h00;
    bit         m_werr = 1'b0;
    bit         m_rerr = 1'b0;
    bit         use_b = 1'b0;

    localparam logic [21:0] RESET_VEC = {8'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    function automatic logic [21:0] exp_vec();
        int n;
        n = mq.size();
        return {8'(n), 8'(mmax), (n == mdepth), (n == 0), (n >= maf), (n <= mae), m_werr, m_rerr};
    endfunction

    function automatic logic [21:0] obs_vec();
        if (use_b)
            return {8'(b_count), 8'(b_max), b_full, b_empty, b_af, b_ae, b_werr, b_rerr};
        else
            return {8'(a_count), 8'(a_max), a_full, a_empty, a_af, a_ae, a_werr, a_rerr};
    endfunction

    function automatic logic [7:0] obs_rdata();
        return use_b ? b_rdata : a_rdata;
    endfunction

    // Drive one cycle of stimulus and advance the model by the FIFO rules.
    task automatic tick(input bit w, input logic [7:0] d, input bit r, input bit f, input bit rs);
        bit was_full, was_empty;
        wr_en = w; wdata = d; rd_en = r; flush = f; rst = rs;
        if (rs) begin
            mq.delete(); mmax = 0; m_rdata = 8'h00; m_werr = 1'b0; m_rerr = 1'b0;
        end else if (f) begin
            mq.delete(); mmax = 0; m_werr = 1'b0; m_rerr = 1'b0;
        end else begin
            was_full  = (mq.size() == mdepth);
            was_empty = (mq.size() == 0);
            m_werr = w & was_full;
            m_rerr = r & was_empty;
            if (r && !was_empty) m_rdata = mq.pop_front();
            if (w && !was_full) mq.push_back(d);
            if (mq.size() > mmax) mmax = mq.size();
        end
        @(posedge clk);
        #1;
        wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; rst = 1'b0;
    endtask

    task automatic select(input bit b);
        use_b = b;
        mdepth = b ? 10 : 16;
        maf = b ? 8 : 14;
        mae = b ? 3 : 2;
        tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        select(1'b0);
        n_tests++;
        if (obs_vec() !== RESET_VEC) begin
            n_fail++; $display("FAIL reset_status got %h exp %h", obs_vec(), RESET_VEC);
        end
        n_tests++;
        if (a_rdata !== 8'h00) begin
            n_fail++; $display("FAIL reset_rdata got %h exp 00", a_rdata);
        end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 16; i++) begin
            tick(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
            n_tests++;
            if (a_count !== 5'(i) || a_af !== (i >= 14) || a_full !== (i == 16)) begin
                n_fail++; $display("FAIL fill i=%0d count %0d af %b full %b", i, a_count, a_af, a_full);
            end
        end
        n_tests++;
        if (a_max !== 5'd16 || obs_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL fill_final got %h exp %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 16; i++) begin
            tick(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            n_tests++;
            if (a_rdata !== 8'(i + 1) || a_ae !== ((15 - i) <= 2) || a_max !== 5'd16) begin
                n_fail++; $display("FAIL drain i=%0d rdata %h exp %h ae %b max %0d", i, a_rdata, 8'(i + 1), a_ae, a_max);
            end
        end
        n_tests++;
        if (a_empty !== 1'b1 || obs_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL drain_final got %h exp %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_errors();
        logic [7:0] last;
        for (int i = 0; i < 16; i++) tick(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b0);
        tick(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (a_werr !== 1'b1 || a_count !== 5'd16) begin
            n_fail++; $display("FAIL overflow werr %b count %0d exp 1/16", a_werr, a_count);
        end
        tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (a_werr !== 1'b0) begin
            n_fail++; $display("FAIL overflow_pulse werr %b exp 0", a_werr);
        end
        for (int i = 0; i < 16; i++) begin
            tick(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            n_tests++;
            if (a_rdata !== 8'(8'h20 + i)) begin
                n_fail++; $display("FAIL intact i=%0d rdata %h exp %h", i, a_rdata, 8'(8'h20 + i));
            end
        end
        last = 8'h2F;
        tick(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (a_rerr !== 1'b1 || a_rdata !== last || a_count !== 5'd0) begin
            n_fail++; $display("FAIL underflow rerr %b rdata %h exp 1/%h", a_rerr, a_rdata, last);
        end
        tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (a_rerr !== 1'b0) begin
            n_fail++; $display("FAIL underflow_pulse rerr %b exp 0", a_rerr);
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 16; i++) tick(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
        tick(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (a_rdata !== 8'h40 || a_werr !== 1'b1 || a_count !== 5'd15) begin
            n_fail++; $display("FAIL full_wr_rd rdata %h werr %b count %0d exp 40/1/15", a_rdata, a_werr, a_count);
        end
        for (int i = 1; i < 16; i++) begin
            tick(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            n_tests++;
            if (a_rdata !== 8'(8'h40 + i) || obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL full_wr_rd_drain i=%0d rdata %h status %h exp %h", i, a_rdata, obs_vec(), exp_vec());
            end
        end
        tick(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (a_rerr !== 1'b1 || a_count !== 5'd1 || a_rdata !== 8'h4F) begin
            n_fail++; $display("FAIL empty_wr_rd rerr %b count %0d rdata %h exp 1/1/4f", a_rerr, a_count, a_rdata);
        end
        tick(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (a_rdata !== 8'h5A || a_count !== 5'd0) begin
            n_fail++; $display("FAIL empty_wr_rd_read rdata %h count %0d exp 5a/0", a_rdata, a_count);
        end
    endtask

    task automatic test_random_depth10();
        int pw, pr, writes;
        bit w, r;
        select(1'b1);
        writes = 0;
        for (int c = 0; c < 300; c++) begin
            pw = (c < 100) ? 80 : (c < 200) ? 30 : 50;
            pr = (c < 100) ? 30 : (c < 200) ? 80 : 50;
            w = ($urandom_range(0, 99) < pw);
            r = ($urandom_range(0, 99) < pr);
            if (w && mq.size() < 10) writes++;
            tick(w, 8'($urandom), r, 1'b0, 1'b0);
            n_tests++;
            if (obs_vec() !== exp_vec() || b_rdata !== m_rdata) begin
                n_fail++; $display("FAIL random c=%0d status %h exp %h rdata %h exp %h", c, obs_vec(), exp_vec(), b_rdata, m_rdata);
            end
            n_tests++;
            if (b_count > 4'd10 || b_full !== (b_count == 4'd10) || b_empty !== (b_count == 4'd0)
                || b_af !== (b_count >= 4'd8) || b_ae !== (b_count <= 4'd3)) begin
                n_fail++; $display("FAIL random_flags c=%0d count %0d full %b empty %b af %b ae %b", c, b_count, b_full, b_empty, b_af, b_ae);
            end
        end
        n_tests++;
        if (writes < 11) begin
            n_fail++; $display("FAIL random_wrap accepted writes %0d need >= 11", writes);
        end
    endtask

    task automatic test_flush_reset();
        select(1'b0);
        for (int i = 0; i < 8; i++) tick(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
        tick(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 8'h99, 1'b0, 1'b1, 1'b0);
        n_tests++;
        if (obs_vec() !== RESET_VEC || a_rdata !== 8'h60) begin
            n_fail++; $display("FAIL flush status %h exp %h rdata %h exp 60", obs_vec(), RESET_VEC, a_rdata);
        end
        for (int i = 0; i < 3; i++) tick(1'b1, 8'(8'h70 + i), 1'b0, 1'b0, 1'b0);
        tick(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (a_rdata !== 8'h70 || obs_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL post_flush rdata %h exp 70 status %h exp %h", a_rdata, obs_vec(), exp_vec());
        end
        tick(1'b1, 8'hBB, 1'b1, 1'b0, 1'b1);
        n_tests++;
        if (obs_vec() !== RESET_VEC || a_rdata !== 8'h00) begin
            n_fail++; $display("FAIL mid_reset status %h exp %h rdata %h exp 00", obs_vec(), RESET_VEC, a_rdata);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_fill();
        test_drain();
        test_errors();
        test_simultaneous();
        test_random_depth10();
        test_flush_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
